// File: rtl/full_adder_unit_if.sv
// Operand/result bundle for full_adder_unit: addends, carry-in and valid in;
// sum, carry-out, signed overflow and valid out.
interface full_adder_unit_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C;
  logic             in_valid;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             out_valid;
  logic             overflow;

  modport master (
    output A, B, C, in_valid,
    input  Sum, Carry, out_valid, overflow
  );

  modport slave (
    input  A, B, C, in_valid,
    output Sum, Carry, out_valid, overflow
  );
endinterface

// File: rtl/full_adder_unit.sv
// WIDTH-bit ripple-carry adder built from 1-bit full-adder cells, with an
// optional output register stage that tracks a valid strobe.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module full_adder_unit #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  full_adder_unit_if.slave   bus
);

  logic [WIDTH:0]   carry_c;
  logic [WIDTH-1:0] sum_c;
  logic             ovf_c;

  assign carry_c[0] = bus.C;

  // One cell per bit; carry ripples LSB to MSB.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (bus.A[i]),
      .b  (bus.B[i]),
      .ci (carry_c[i]),
      .s  (sum_c[i]),
      .co (carry_c[i+1])
    );
  end

  // Carry into MSB vs carry out of MSB; for WIDTH=1 the carry into the MSB is C.
  assign ovf_c = carry_c[WIDTH-1] ^ carry_c[WIDTH];

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;
    logic             valid_q;

    // Results load only on valid input, so idle inputs never disturb held values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
        ovf_q   <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          sum_q   <= sum_c;
          carry_q <= carry_c[WIDTH];
          ovf_q   <= ovf_c;
        end
      end
    end

    assign bus.Sum       = sum_q;
    assign bus.Carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.out_valid = valid_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign bus.Sum       = sum_c;
    assign bus.Carry     = carry_c[WIDTH];
    assign bus.overflow  = ovf_c;
    assign bus.out_valid = bus.in_valid;
  end

endmodule

// File: tb/tb_full_adder_unit.sv
// Self-checking bench for full_adder_unit: exhaustive 1-bit tables, 8-bit corner
// cases, hold and mid-stream reset, and a random 16-bit run against A+B+C.
module tb_full_adder_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  full_adder_unit_if #(.WIDTH(1))  if_w1r ();
  full_adder_unit_if #(.WIDTH(1))  if_w1c ();
  full_adder_unit_if #(.WIDTH(8))  if_w8  ();
  full_adder_unit_if #(.WIDTH(16)) if_w16 ();

  full_adder_unit #(.WIDTH(1),  .REG_OUT(1'b1)) u_w1r (.clk(clk), .rst_n(rst_n), .bus(if_w1r));
  full_adder_unit #(.WIDTH(1),  .REG_OUT(1'b0)) u_w1c (.clk(clk), .rst_n(rst_n), .bus(if_w1c));
  full_adder_unit #(.WIDTH(8),  .REG_OUT(1'b1)) u_w8  (.clk(clk), .rst_n(rst_n), .bus(if_w8));
  full_adder_unit #(.WIDTH(16), .REG_OUT(1'b1)) u_w16 (.clk(clk), .rst_n(rst_n), .bus(if_w16));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Signed overflow: the two's-complement sum of A and B plus carry-in leaves the w-bit range.
  function automatic logic ovf_ref(input int w, input longint a, input longint b, input longint c);
    longint half, sa, sb, s;
    half = longint'(1) << (w - 1);
    sa   = (a >= half) ? a - 2 * half : a;
    sb   = (b >= half) ? b - 2 * half : b;
    s    = sa + sb + c;
    return (s < -half) || (s >= half);
  endfunction

  initial begin
    int     vcount;
    int     a, b, c, tot;
    logic   v;
    longint exp_tot;
    logic   exp_ovf;

    rst_n = 1'b0;
    if_w1r.A = '0; if_w1r.B = '0; if_w1r.C = 1'b0; if_w1r.in_valid = 1'b0;
    if_w1c.A = '0; if_w1c.B = '0; if_w1c.C = 1'b0; if_w1c.in_valid = 1'b0;
    if_w8.A  = '0; if_w8.B  = '0; if_w8.C  = 1'b0; if_w8.in_valid  = 1'b0;
    if_w16.A = '0; if_w16.B = '0; if_w16.C = 1'b0; if_w16.in_valid = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_w1_sum",   64'(if_w1r.Sum),       64'd0);
    check("rst_w1_carry", 64'(if_w1r.Carry),     64'd0);
    check("rst_w1_ovf",   64'(if_w1r.overflow),  64'd0);
    check("rst_w1_valid", 64'(if_w1r.out_valid), 64'd0);
    check("rst_w8_sum",   64'(if_w8.Sum),        64'd0);
    check("rst_w8_valid", 64'(if_w8.out_valid),  64'd0);
    check("rst_w16_sum",  64'(if_w16.Sum),       64'd0);
    rst_n = 1'b1;

    // 1-bit registered truth table, one vector per cycle.
    vcount = 0;
    for (int n = 0; n < 10; n++) begin
      a = (n >> 2) & 1; b = (n >> 1) & 1; c = n & 1;
      if_w1r.A = 1'(a); if_w1r.B = 1'(b); if_w1r.C = 1'(c);
      if_w1r.in_valid = (n < 8);
      @(negedge clk);
      vcount += int'(if_w1r.out_valid);
      if (n < 8) begin
        tot = a + b + c;
        check("w1r_sum",   64'(if_w1r.Sum),       64'(tot % 2));
        check("w1r_carry", 64'(if_w1r.Carry),     64'(tot / 2));
        check("w1r_ovf",   64'(if_w1r.overflow),  64'(ovf_ref(1, a, b, c)));
        check("w1r_valid", 64'(if_w1r.out_valid), 64'd1);
      end
    end
    check("w1r_valid_cnt", 64'(vcount), 64'd8);

    // 1-bit combinational truth table, 10 ns apart.
    for (int n = 0; n < 8; n++) begin
      a = (n >> 2) & 1; b = (n >> 1) & 1; c = n & 1;
      if_w1c.A = 1'(a); if_w1c.B = 1'(b); if_w1c.C = 1'(c);
      if_w1c.in_valid = 1'b1;
      #1;
      tot = a + b + c;
      check("w1c_sum",   64'(if_w1c.Sum),       64'(tot % 2));
      check("w1c_carry", 64'(if_w1c.Carry),     64'(tot / 2));
      check("w1c_ovf",   64'(if_w1c.overflow),  64'(ovf_ref(1, a, b, c)));
      check("w1c_valid", 64'(if_w1c.out_valid), 64'd1);
      #9;
    end
    if_w1c.in_valid = 1'b0;
    #1;
    check("w1c_valid_low", 64'(if_w1c.out_valid), 64'd0);
    @(negedge clk);

    // 8-bit corners: full carry ripple, then signed overflow.
    if_w8.A = 8'hFF; if_w8.B = 8'h00; if_w8.C = 1'b1; if_w8.in_valid = 1'b1;
    @(negedge clk);
    check("w8_ff_sum",   64'(if_w8.Sum),      64'h00);
    check("w8_ff_carry", 64'(if_w8.Carry),    64'd1);
    check("w8_ff_ovf",   64'(if_w8.overflow), 64'd0);
    if_w8.A = 8'h7F; if_w8.B = 8'h01; if_w8.C = 1'b0;
    @(negedge clk);
    check("w8_7f_sum",   64'(if_w8.Sum),       64'h80);
    check("w8_7f_carry", 64'(if_w8.Carry),     64'd0);
    check("w8_7f_ovf",   64'(if_w8.overflow),  64'd1);
    check("w8_7f_valid", 64'(if_w8.out_valid), 64'd1);
    if_w8.in_valid = 1'b0;
    @(negedge clk);

    // Hold: one valid 1+1+0, then idle with toggling inputs.
    if_w1r.A = 1'b1; if_w1r.B = 1'b1; if_w1r.C = 1'b0; if_w1r.in_valid = 1'b1;
    @(negedge clk);
    check("hold_first_valid", 64'(if_w1r.out_valid), 64'd1);
    if_w1r.in_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      if_w1r.A = 1'($urandom); if_w1r.B = 1'($urandom); if_w1r.C = 1'($urandom);
      @(negedge clk);
      check("hold_sum",   64'(if_w1r.Sum),       64'd0);
      check("hold_carry", 64'(if_w1r.Carry),     64'd1);
      check("hold_ovf",   64'(if_w1r.overflow),  64'd1);
      check("hold_valid", 64'(if_w1r.out_valid), 64'd0);
    end

    // Reset asserted between edges while a result is valid.
    if_w8.A = 8'h7F; if_w8.B = 8'h01; if_w8.C = 1'b0; if_w8.in_valid = 1'b1;
    @(negedge clk);
    check("mid_pre_valid", 64'(if_w8.out_valid), 64'd1);
    if_w8.A = 8'h55; if_w8.B = 8'h11;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sum",   64'(if_w8.Sum),       64'd0);
    check("mid_rst_carry", 64'(if_w8.Carry),     64'd0);
    check("mid_rst_ovf",   64'(if_w8.overflow),  64'd0);
    check("mid_rst_valid", 64'(if_w8.out_valid), 64'd0);
    @(negedge clk);
    check("mid_discard_valid", 64'(if_w8.out_valid), 64'd0);
    check("mid_discard_sum",   64'(if_w8.Sum),       64'd0);
    rst_n = 1'b1;
    if_w8.A = 8'h10; if_w8.B = 8'h20; if_w8.C = 1'b1;
    @(negedge clk);
    check("mid_post_sum",   64'(if_w8.Sum),       64'h31);
    check("mid_post_valid", 64'(if_w8.out_valid), 64'd1);
    if_w8.in_valid = 1'b0;
    @(negedge clk);
    check("mid_post_idle", 64'(if_w8.out_valid), 64'd0);

    // Random 16-bit run; idle cycles must hold the last captured result.
    exp_tot = 0;
    exp_ovf = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 65535));
      c = int'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) != 0);
      if_w16.A = 16'(a); if_w16.B = 16'(b); if_w16.C = 1'(c); if_w16.in_valid = v;
      @(negedge clk);
      if (v) begin
        exp_tot = longint'(a) + longint'(b) + longint'(c);
        exp_ovf = ovf_ref(16, a, b, c);
      end
      check("rnd_valid", 64'(if_w16.out_valid), 64'(v));
      check("rnd_total", 64'({if_w16.Carry, if_w16.Sum}), 64'(exp_tot));
      check("rnd_ovf",   64'(if_w16.overflow), 64'(exp_ovf));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
